poly_load_ctrl_multi: RTL and testbench
=======================================

# poly_load_ctrl_multi

Parametrised BRAM polynomial-load sequencer. It streams the words of `NUM_POLY` consecutive polynomials out of a coefficient BRAM at a configurable base address, and generates read strobes, word and polynomial indices, and a read-latency-aligned data-valid. It handles downstream stall, restart by `start`, and a sticky done flag. It sits between the top-level controller and the BRAM read port that feeds the multiplier/accumulator datapath.

## Interface
Parameters:
- `ADDR_W`, 8: BRAM address width.
- `WORDS_PER_POLY`, 16: words per polynomial. Must be at least 2.
- `NUM_POLY`, 4: polynomials per load burst. Must be at least 1.
- `BASE_ADDR`, 0: address of word 0 of polynomial 0.
- `READ_LAT`, 1: BRAM read latency in cycles, allowed range 1 to 4.

Ports:
- `clk`, input, 1: clock. All logic is rising-edge.
- `rst_n`, input, 1: reset. Asynchronous, active-low.
- `start`, input, 1: single-cycle request to begin a burst. Honoured only in IDLE or DONE.
- `stall`, input, 1: downstream not ready. Freezes read issue.
- `s_address`, output, `ADDR_W`: BRAM read address. Meaningful only when `rd_en` is high.
- `rd_en`, output, 1: BRAM read strobe.
- `poly_idx`, output, `max(1,$clog2(NUM_POLY))`: polynomial of the current `s_address`.
- `word_idx`, output, `$clog2(WORDS_PER_POLY)`: word within the polynomial.
- `data_valid`, output, 1: `rd_en` delayed by exactly `READ_LAT` cycles. Marks valid BRAM output.
- `last_word`, output, 1: `data_valid` for the final word of each polynomial, delayed the same way.
- `busy`, output, 1: high in LOAD and DRAIN.
- `poly_load_done`, output, 1: high in DONE.

## Operation
- `TOTAL = NUM_POLY*WORDS_PER_POLY`.
- Elaboration fails if `BASE_ADDR + TOTAL > 2**ADDR_W`. Address arithmetic therefore never wraps.
- The address is registered: `s_address = BASE_ADDR + poly_idx*WORDS_PER_POLY + word_idx`. It is maintained incrementally; there is no multiplier.
- States:
  - IDLE: reset state.
  - LOAD: issues reads.
  - DRAIN: waits for outstanding reads.
  - DONE: sticky.
- Transitions:
  - IDLE or DONE, with `start`: go to LOAD. Indices and the address are cleared to word 0, poly 0.
  - LOAD: `rd_en = !stall`, combinational.
    - On each cycle with `rd_en`, `word_idx` increments.
    - At `WORDS_PER_POLY-1`, `word_idx` wraps to 0 and `poly_idx` increments.
    - The read of the last word, (`NUM_POLY-1`, `WORDS_PER_POLY-1`), moves to DRAIN. Indices hold at their last values.
  - LOAD with `stall` high: indices and address hold, `rd_en` is low, and the state stays in LOAD. Stall may assert on any cycle, including the last-word cycle; that read is then deferred.
  - DRAIN: a down-counter loaded with `READ_LAT`. When it reaches 0 (the last `data_valid` has been presented), go to DONE.
  - DONE: `poly_load_done` stays high until a new `start`.
- `start` in LOAD or DRAIN is ignored. There is no queuing.
- `stall` outside LOAD has no effect.
- The valid pipeline shifts every cycle regardless of `stall`, because reads already issued complete.
- `last_word` travels in the same pipeline as a second bit.
- Reset mid-burst: all state returns to reset values immediately and asynchronously, in-flight valids are discarded, and there is no spurious `data_valid` after release.
- Reset values: state IDLE; `s_address` = `BASE_ADDR`; `poly_idx`, `word_idx`, `data_valid`, `last_word`, `busy`, `poly_load_done` all 0. `rd_en` is 0 because the state is not LOAD.

## Timing
- Take `start` sampled high at edge 0. LOAD runs from cycle 1, and the first `rd_en` with address `BASE_ADDR` is in cycle 1.
- With no stall:
  - `rd_en` is high in cycles 1 to `TOTAL`.
  - `data_valid` is high in cycles `1+READ_LAT` to `TOTAL+READ_LAT`.
  - `busy` is high in cycles 1 to `TOTAL+READ_LAT`.
  - `poly_load_done` rises in cycle `TOTAL+READ_LAT+1`.
- Each stall cycle in LOAD adds exactly one cycle to every later event.
- `start` coincident with DONE: `poly_load_done` drops in the next cycle, and `rd_en` rises that same cycle.
- Throughput: one word per unstalled cycle. There is no bubble between polynomials.

## Structure
- Package `poly_load_pkg`:
  - state enum: IDLE, LOAD, DRAIN, DONE (2-bit);
  - `READ_LAT` range limits;
  - a function computing index widths (minimum 1 bit).
- Sub-module `poly_load_valid_pipe`: a `READ_LAT`-deep, 2-bit shift register carrying {last, valid}, with asynchronous active-low clear.
- Everything else (FSM, counters, address incrementer) stays in the top module.

## Test plan
- Defaults, with `start` pulsed at cycle 0:
  - `s_address` runs 0 to 63 over cycles 1 to 64;
  - `poly_idx` steps to 1 at address 16;
  - `data_valid` is high in cycles 2 to 65;
  - `last_word` is high in cycles 17, 33, 49 and 65;
  - `poly_load_done` is high from cycle 66.
- `BASE_ADDR=64`, `READ_LAT=3`, `NUM_POLY=2`: addresses run 64 to 95, `data_valid` is high in cycles 4 to 35, done is high from cycle 36.
- `stall` high for 5 cycles at address 20, and again on the last-word cycle: the address holds at 20 throughout, the total burst stretches by 6 cycles, and no address is skipped or duplicated.
- `start` pulsed at cycle 10 of a burst: ignored. Later, `start` while done is high: done clears next cycle and address 0 is reissued.
- `rst_n` low at cycle 30 for 1 cycle, then released: all outputs return to 0 (`s_address` to `BASE_ADDR`) immediately, there is no `data_valid` afterwards, and the block stays IDLE until `start`.
- `BASE_ADDR=250`, `ADDR_W=8`, defaults otherwise: elaboration error.

Source files
------------

// File: rtl/poly_load_pkg.sv
// Shared types and helpers for the polynomial-load sequencer.
package poly_load_pkg;

    localparam int unsigned READ_LAT_MIN = 1;
    localparam int unsigned READ_LAT_MAX = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/poly_load_valid_pipe.sv
// Fixed-depth {last, valid} delay line matching the BRAM read latency.
module poly_load_valid_pipe #(
    parameter int unsigned DEPTH = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] in_i,
    output logic [1:0] out_o
);

    logic [1:0] pipe_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= in_i;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign out_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/poly_load_ctrl_multi.sv
// Streams NUM_POLY consecutive polynomials out of a coefficient BRAM
// with read strobes, indices and a latency-aligned data-valid.
module poly_load_ctrl_multi
    import poly_load_pkg::*;
#(
    parameter int unsigned ADDR_W         = 8,
    parameter int unsigned WORDS_PER_POLY = 16,
    parameter int unsigned NUM_POLY       = 4,
    parameter int unsigned BASE_ADDR      = 0,
    parameter int unsigned READ_LAT       = 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    input  logic                                stall,
    output logic [ADDR_W-1:0]                   s_address,
    output logic                                rd_en,
    output logic [idx_w(NUM_POLY)-1:0]          poly_idx,
    output logic [idx_w(WORDS_PER_POLY)-1:0]    word_idx,
    output logic                                data_valid,
    output logic                                last_word,
    output logic                                busy,
    output logic                                poly_load_done
);

    localparam int unsigned PW = idx_w(NUM_POLY);
    localparam int unsigned WW = idx_w(WORDS_PER_POLY);
    localparam longint SPAN =
        longint'(BASE_ADDR) + longint'(NUM_POLY) * longint'(WORDS_PER_POLY);

    if (WORDS_PER_POLY < 2) begin : g_bad_words
        $error("WORDS_PER_POLY must be at least 2");
    end
    if (NUM_POLY < 1) begin : g_bad_polys
        $error("NUM_POLY must be at least 1");
    end
    if (READ_LAT < READ_LAT_MIN || READ_LAT > READ_LAT_MAX) begin : g_bad_lat
        $error("READ_LAT out of range");
    end
    if (SPAN > (longint'(1) << ADDR_W)) begin : g_bad_span
        $error("burst does not fit in the BRAM address space");
    end

    state_e          state_q, state_d;
    logic [WW-1:0]   word_q, word_d;
    logic [PW-1:0]   poly_q, poly_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]      drain_q, drain_d;
    logic            word_last, poly_last;
    logic [1:0]      pipe_out;

    assign word_last = (word_q == WW'(WORDS_PER_POLY - 1));
    assign poly_last = (poly_q == PW'(NUM_POLY - 1));

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        poly_d  = poly_q;
        addr_d  = addr_q;
        drain_d = drain_q;
        rd_en   = (state_q == ST_LOAD) && !stall;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    word_d  = '0;
                    poly_d  = '0;
                    addr_d  = ADDR_W'(BASE_ADDR);
                end
            end
            ST_LOAD: begin
                if (rd_en) begin
                    // Indices freeze on the final word so they stay readable.
                    if (word_last && poly_last) begin
                        state_d = ST_DRAIN;
                        drain_d = 3'(READ_LAT - 1);
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                        if (word_last) begin
                            word_d = '0;
                            poly_d = poly_q + PW'(1);
                        end else begin
                            word_d = word_q + WW'(1);
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q - 3'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            word_q  <= '0;
            poly_q  <= '0;
            addr_q  <= ADDR_W'(BASE_ADDR);
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            poly_q  <= poly_d;
            addr_q  <= addr_d;
            drain_q <= drain_d;
        end
    end

    poly_load_valid_pipe #(
        .DEPTH (READ_LAT)
    ) u_valid_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .in_i  ({rd_en && word_last, rd_en}),
        .out_o (pipe_out)
    );

    assign s_address      = addr_q;
    assign poly_idx       = poly_q;
    assign word_idx       = word_q;
    assign data_valid     = pipe_out[0];
    assign last_word      = pipe_out[1];
    assign busy           = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
    assign poly_load_done = (state_q == ST_DONE);

endmodule

// File: tb/tb_poly_load_ctrl_multi.sv
// Scoreboard bench: stimulus pushes expected reads, valids and status
// per cycle; a negedge monitor pops and compares.
module tb_poly_load_ctrl_multi;

    localparam int AW    = 8;
    localparam int W     = 16;
    localparam int N     = 4;
    localparam int BASE  = 8;
    localparam int LAT   = 2;
    localparam int TOTAL = N * W;

    typedef struct {
        int cyc;
        int addr;
        int poly;
        int word;
    } rd_t;

    typedef struct {
        int cyc;
        bit last;
    } dv_t;

    typedef struct {
        int cyc;
        bit busy;
        bit done;
    } st_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          stall = 1'b0;
    logic [AW-1:0] s_address;
    logic          rd_en;
    logic [1:0]    poly_idx;
    logic [3:0]    word_idx;
    logic          data_valid;
    logic          last_word;
    logic          busy;
    logic          poly_load_done;

    rd_t rd_q [$];
    dv_t dv_q [$];
    st_t st_q [$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit mon_en  = 1'b0;
    bit m_done  = 1'b0;

    poly_load_ctrl_multi #(
        .ADDR_W         (AW),
        .WORDS_PER_POLY (W),
        .NUM_POLY       (N),
        .BASE_ADDR      (BASE),
        .READ_LAT       (LAT)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .stall          (stall),
        .s_address      (s_address),
        .rd_en          (rd_en),
        .poly_idx       (poly_idx),
        .word_idx       (word_idx),
        .data_valid     (data_valid),
        .last_word      (last_word),
        .busy           (busy),
        .poly_load_done (poly_load_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d",
                     nm, cyc, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        rd_t r;
        dv_t d;
        st_t s;
        if (mon_en) begin
            if (rd_q.size() != 0 && rd_q[0].cyc == cyc) begin
                r = rd_q.pop_front();
                chk("rd_en", int'(rd_en), 1);
                if (rd_en) begin
                    chk("s_address", int'(s_address), r.addr);
                    chk("poly_idx", int'(poly_idx), r.poly);
                    chk("word_idx", int'(word_idx), r.word);
                end
            end else begin
                chk("rd_en_quiet", int'(rd_en), 0);
            end
            if (dv_q.size() != 0 && dv_q[0].cyc == cyc) begin
                d = dv_q.pop_front();
                chk("data_valid", int'(data_valid), 1);
                chk("last_word", int'(last_word), int'(d.last));
            end else begin
                chk("data_valid_quiet", int'(data_valid), 0);
                chk("last_word_quiet", int'(last_word), 0);
            end
            if (st_q.size() != 0 && st_q[0].cyc == cyc) begin
                s = st_q.pop_front();
                chk("busy", int'(busy), int'(s.busy));
                chk("poly_load_done", int'(poly_load_done), int'(s.done));
            end
        end
    end

    task automatic check_reset();
        chk("rst_s_address", int'(s_address), BASE);
        chk("rst_poly_idx", int'(poly_idx), 0);
        chk("rst_word_idx", int'(word_idx), 0);
        chk("rst_rd_en", int'(rd_en), 0);
        chk("rst_data_valid", int'(data_valid), 0);
        chk("rst_last_word", int'(last_word), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(poly_load_done), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        stall = 1'b0;
        start = 1'b0;
        #1;
        rd_q.delete();
        dv_q.delete();
        st_q.delete();
        check_reset();
        m_done = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            st_q.push_back('{cyc, 1'b0, m_done});
            stall = 1'($urandom_range(1));
            @(posedge clk);
            #1;
        end
        stall = 1'b0;
    endtask

    // mode 0: no stall, 1: random stall, 2: 5-cycle hold at address 20
    // plus one stall on the final word.
    task automatic run_burst(input int mode, input bit ign, input int rst_at);
        int k;
        int e;
        int p;
        int hold;
        bit hl;
        bit s;
        k = 0;
        hold = 0;
        hl = 1'b0;
        start = 1'b1;
        st_q.push_back('{cyc, 1'b0, m_done});
        @(posedge clk);
        #1;
        start = 1'b0;
        e = cyc;
        p = cyc;
        while (k < TOTAL) begin
            if (rst_at >= 0 && p == e + rst_at) begin
                do_reset();
                return;
            end
            case (mode)
                0: s = 1'b0;
                1: s = ($urandom_range(3) == 0) && (p - e < 8 * TOTAL);
                default: begin
                    if (k == 20 - BASE && hold < 5) begin
                        s = 1'b1;
                        hold++;
                    end else if (k == TOTAL - 1 && !hl) begin
                        s = 1'b1;
                        hl = 1'b1;
                    end else begin
                        s = 1'b0;
                    end
                end
            endcase
            stall = s;
            st_q.push_back('{p, 1'b1, 1'b0});
            if (!s) begin
                rd_q.push_back('{p, BASE + k, k / W, k % W});
                dv_q.push_back('{p + LAT, (k % W) == W - 1});
                k++;
            end
            start = ign && (p == e + 10);
            @(posedge clk);
            #1;
            p = cyc;
        end
        start = 1'b0;
        for (int j = 0; j < LAT; j++) begin
            st_q.push_back('{p + j, 1'b1, 1'b0});
        end
        st_q.push_back('{p + LAT, 1'b0, 1'b1});
        m_done = 1'b1;
        for (int j = 0; j <= LAT; j++) begin
            stall = 1'($urandom_range(1));
            @(posedge clk);
            #1;
        end
        stall = 1'b0;
    endtask

    initial begin
        #2;
        rst_n = 1'b0;
        #1;
        check_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mon_en = 1'b1;
        idle(3);
        run_burst(0, 1'b0, -1);
        idle(4);
        run_burst(2, 1'b1, -1);
        idle(2);
        repeat (3) run_burst(1, 1'b0, -1);
        run_burst(1, 1'b0, 30);
        idle(10);
        run_burst(0, 1'b0, -1);
        idle(3);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
